uart_byte_rx: RTL and testbench

- UART receiver that deserialises the raw board RX pin into bytes for the snake direction decoder.
- Outputs `rx_data_t` (received byte) and a single-cycle `rx_data_done` strobe, which feed the key-decoding stage directly.
- Runs on the LCD pixel clock domain. The asynchronous RX pin is synchronised internally.
- Frame format is fixed at 8N1, LSB first.

---
 rtl/uart_byte_rx.sv | 121 ++++++++++++
 tb/tb_uart_byte_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver on the LCD pixel clock: synchronises the raw RX pin and
// delivers each correctly framed byte with a one-cycle done strobe.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       lcd_pclk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data_t,
    output logic       rx_data_done,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W    = $clog2(BAUD_CNT);

    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(BAUD_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(BAUD_CNT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Fewer than 4 clocks per bit leaves no usable mid-bit sample point.
    if (BAUD_CNT < 4) begin : g_baudCheck
        $error("uart_byte_rx: BAUD_CNT (CLK_FREQ/UART_BPS) must be at least 4");
    end

    logic             r_sync0;
    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             w_startEdge;

    assign w_startEdge = !r_sync1 && r_sync2;
    assign rx_busy     = (r_state != S_IDLE);

    // Synchroniser and edge flops preset high so reset looks like an idle line.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync0 <= uart_rxd;
            r_sync1 <= r_sync0;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bitIdx     <= 3'd0;
            r_shift      <= 8'h00;
            rx_data_t    <= 8'h00;
            rx_data_done <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_data_done <= 1'b0;
            rx_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_startEdge) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_MAX) begin
                        r_cnt    <= '0;
                        r_bitIdx <= 3'd0;
                        r_state  <= r_sync1 ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_MAX) begin
                        r_cnt             <= '0;
                        r_shift[r_bitIdx] <= r_sync1;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be caught.
                    if (r_cnt == FULL_MAX) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_sync1) begin
                            rx_data_t    <= r_shift;
                            rx_data_done <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 10 clocks per bit; frames are driven
// bit by bit and the strobes are tallied by a negedge monitor.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BAUD     = CLK_FREQ / UART_BPS;

    logic       lcd_pclk;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data_t;
    logic       rx_data_done;
    logic       rx_frame_err;
    logic       rx_busy;

    int testsRun   = 0;
    int failCount  = 0;
    int cycleCount = 0;
    int doneCount  = 0;
    int errCount   = 0;
    int bothCount  = 0;
    int busyCount  = 0;
    int lastStartCycle = 0;
    logic [7:0] dataQ[$];
    int         doneCycleQ[$];

    uart_byte_rx #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .rx_data_t   (rx_data_t),
        .rx_data_done(rx_data_done),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    initial lcd_pclk = 1'b0;
    always #5 lcd_pclk = ~lcd_pclk;

    always @(posedge lcd_pclk) cycleCount <= cycleCount + 1;

    // Strobes are tallied mid-cycle so every pulse is seen exactly once.
    always @(negedge lcd_pclk) begin
        if (rx_data_done) begin
            doneCount++;
            dataQ.push_back(rx_data_t);
            doneCycleQ.push_back(cycleCount);
        end
        if (rx_frame_err) errCount++;
        if (rx_data_done && rx_frame_err) bothCount++;
        if (rx_busy) busyCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge lcd_pclk);
        #1;
    endtask

    task automatic driveBit(input logic b, input int n);
        uart_rxd = b;
        waitCycles(n);
    endtask

    // Drives one 8N1 frame LSB first; caller must be at posedge+1.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        lastStartCycle = cycleCount;
        driveBit(1'b0, BAUD);
        for (int i = 0; i < 8; i++) driveBit(data[i], BAUD);
        driveBit(stopBit, BAUD);
    endtask

    int expDone;
    int busyBefore;
    int latency;

    initial begin
        rst      = 1'b1;
        uart_rxd = 1'b1;
        waitCycles(5);

        checkOutput("reset_data",   32'(rx_data_t), 32'h00);
        checkOutput("reset_done",   32'(rx_data_done), 32'h0);
        checkOutput("reset_err",    32'(rx_frame_err), 32'h0);
        checkOutput("reset_busy",   32'(rx_busy), 32'h0);

        rst = 1'b0;
        waitCycles(100);
        checkOutput("idle_no_done", 32'(doneCount), 32'd0);
        checkOutput("idle_no_err",  32'(errCount), 32'd0);
        checkOutput("idle_no_busy", 32'(busyCount), 32'd0);

        applyStimulus(8'h05, 1'b1);
        waitCycles(10);
        checkOutput("single_count", 32'(doneCount), 32'd1);
        if (doneCount >= 1) begin
            checkOutput("single_data_pulse", 32'(dataQ[0]), 32'h05);
            latency = doneCycleQ[0] - (lastStartCycle + 1);
            checkOutput("single_latency", 32'(latency >= 96 && latency <= 98), 32'd1);
        end
        checkOutput("single_data_held", 32'(rx_data_t), 32'h05);
        checkOutput("single_no_err", 32'(errCount), 32'd0);

        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h03, 1'b1);
        waitCycles(10);
        checkOutput("b2b_count", 32'(doneCount), 32'd4);
        if (doneCount >= 4) begin
            checkOutput("b2b_data0", 32'(dataQ[1]), 32'h02);
            checkOutput("b2b_data1", 32'(dataQ[2]), 32'h01);
            checkOutput("b2b_data2", 32'(dataQ[3]), 32'h03);
            checkOutput("b2b_gap0", 32'(doneCycleQ[2] - doneCycleQ[1]), 32'd100);
            checkOutput("b2b_gap1", 32'(doneCycleQ[3] - doneCycleQ[2]), 32'd100);
        end
        checkOutput("b2b_no_err", 32'(errCount), 32'd0);

        busyBefore = busyCount;
        driveBit(1'b0, 3);
        driveBit(1'b1, 30);
        checkOutput("glitch_busy_brief",
                    32'((busyCount - busyBefore) > 0 && (busyCount - busyBefore) < 8), 32'd1);
        checkOutput("glitch_no_done", 32'(doneCount), 32'd4);
        checkOutput("glitch_no_err",  32'(errCount), 32'd0);
        checkOutput("glitch_idle",    32'(rx_busy), 32'd0);

        applyStimulus(8'hA5, 1'b0);
        driveBit(1'b0, 50);
        checkOutput("ferr_count",   32'(errCount), 32'd1);
        checkOutput("ferr_no_done", 32'(doneCount), 32'd4);
        checkOutput("ferr_data_kept", 32'(rx_data_t), 32'h03);
        checkOutput("break_idle",   32'(rx_busy), 32'd0);

        driveBit(1'b1, 20);
        applyStimulus(8'h03, 1'b1);
        waitCycles(10);
        expDone = 5;
        checkOutput("after_ferr_count", 32'(doneCount), 32'(expDone));
        checkOutput("after_ferr_data",  32'(rx_data_t), 32'h03);
        checkOutput("after_ferr_errs",  32'(errCount), 32'd1);

        driveBit(1'b0, BAUD);
        for (int i = 0; i < 4; i++) driveBit(1'(8'h55 >> i), BAUD);
        driveBit(1'b0, 5);
        rst = 1'b1;
        waitCycles(3);
        checkOutput("midrst_busy", 32'(rx_busy), 32'd0);
        checkOutput("midrst_data", 32'(rx_data_t), 32'h00);
        uart_rxd = 1'b1;
        rst      = 1'b0;
        waitCycles(120);
        checkOutput("midrst_no_done", 32'(doneCount), 32'(expDone));
        checkOutput("midrst_no_err",  32'(errCount), 32'd1);

        applyStimulus(8'h01, 1'b1);
        waitCycles(10);
        checkOutput("midrst_recover_count", 32'(doneCount), 32'(expDone + 1));
        checkOutput("midrst_recover_data",  32'(rx_data_t), 32'h01);
        checkOutput("never_both_strobes",   32'(bothCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
